// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 M-bit mux datapath.
// Each tenure is capped at MAX_HOLD cycles while another requester is waiting.

module mux_4NtoN #(
  parameter int N = 4
) (
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  input  logic [N-1:0] I2,
  input  logic [N-1:0] I3,
  input  logic [1:0]   S,
  output logic [N-1:0] O
);

  // 4:1 data select
  always_comb begin
    O = {N{1'b0}};
    case (S)
      2'd0:    O = I0;
      2'd1:    O = I1;
      2'd2:    O = I2;
      2'd3:    O = I3;
      default: O = {N{1'b0}};
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int M        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   REQ,
  input  logic [M-1:0] I0,
  input  logic [M-1:0] I1,
  input  logic [M-1:0] I2,
  input  logic [M-1:0] I3,
  output logic [3:0]   GNT,
  output logic [1:0]   S,
  output logic         VALID,
  output logic [M-1:0] O
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_r;
  logic [1:0]    ptr_r;
  logic [CW-1:0] cnt_r;

  logic [3:0]    own_oh_s;
  logic [3:0]    others_s;
  logic [1:0]    idle_pick_s;
  logic [1:0]    sw_pick_s;
  logic          hold_s;
  logic [M-1:0]  mux_o_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // First set bit of mask, searching upward from start with wrap-around.
  function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign own_oh_s    = onehot(S);
  assign others_s    = REQ & ~own_oh_s;
  assign idle_pick_s = pick(REQ, ptr_r);
  assign sw_pick_s   = pick(others_s, S + 2'd1);
  assign hold_s      = REQ[S] && (cnt_r < HOLD_LAST);

  // Arbitration state, tenure counter and registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= {CW{1'b0}};
      GNT     <= 4'b0000;
      S       <= 2'd0;
      VALID   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (REQ != 4'b0000) begin
            GNT     <= onehot(idle_pick_s);
            S       <= idle_pick_s;
            VALID   <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (hold_s) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            ptr_r <= S + 2'd1;
            cnt_r <= {CW{1'b0}};
            if (others_s != 4'b0000) begin
              GNT <= onehot(sw_pick_s);
              S   <= sw_pick_s;
            end else if (!REQ[S]) begin
              // Owner gone and nobody waiting: S keeps the last owner.
              GNT     <= 4'b0000;
              VALID   <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          GNT     <= 4'b0000;
          VALID   <= 1'b0;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  mux_4NtoN #(.N(M)) u_mux (
    .I0 (I0),
    .I1 (I1),
    .I2 (I2),
    .I3 (I3),
    .S  (S),
    .O  (mux_o_s)
  );

  assign O = VALID ? mux_o_s : {M{1'b0}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven, scoreboarded bench for mux4_rr_arbiter (M=4, MAX_HOLD=4).
module tb_mux4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic [3:0] o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] i0 = 4'b0000, i1 = 4'b0000, i2 = 4'b0000, i3 = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic [3:0] o;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic [3:0] d0, d1, d2, d3;
  int n_chk = 0;
  int n_fail = 0;
  int cur = 0;

  mux4_rr_arbiter #(.M(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .REQ(req),
    .I0(i0), .I1(i1), .I2(i2), .I3(i3),
    .GNT(gnt), .S(s), .VALID(valid), .O(o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, cur, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                     input logic [1:0] se, input logic v);
    vec_t e;
    e.rst = r; e.req = q;
    e.i0 = d0; e.i1 = d1; e.i2 = d2; e.i3 = d3;
    e.gnt = g; e.s = se; e.valid = v;
    case (se)
      2'd0: e.o = d0;
      2'd1: e.o = d1;
      2'd2: e.o = d2;
      default: e.o = d3;
    endcase
    if (!v) e.o = 4'b0000;
    vecs.push_back(e);
  endtask

  task automatic invariants();
    chk("gnt_onehot0", {28'd0, gnt & (gnt - 4'd1)}, 32'd0);
    chk("valid_eq_gnt_nz", {31'd0, valid}, {31'd0, gnt != 4'b0000});
    if (valid) chk("gnt_vs_s", {28'd0, gnt}, {28'd0, 4'b0001 << s});
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    rst = v.rst; req = v.req;
    i0 = v.i0; i1 = v.i1; i2 = v.i2; i3 = v.i3;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt", {28'd0, gnt}, {28'd0, e.gnt});
    chk("s", {30'd0, s}, {30'd0, e.s});
    chk("valid", {31'd0, valid}, {31'd0, e.valid});
    chk("o", {28'd0, o}, {28'd0, e.o});
    invariants();
    cur++;
  endtask

  initial begin
    vec_t hv;
    d0 = 4'b0000; d1 = 4'b1000; d2 = 4'b0100; d3 = 4'b1100;
    // Reset with all requests asserted
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    // Full contention: four cycles per owner, then wrap
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        add(1'b0, 4'b1111, 4'b0001 << k, 2'(k), 1'b1);
    for (int c = 0; c < 4; c++) add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    for (int c = 0; c < 4; c++) add(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1);
    for (int c = 0; c < 4; c++) add(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1);
    add(1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1);
    // Reset mid-grant, then the pointer restarts at 0
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // Lone requester 2 held past MAX_HOLD, then released
    d2 = 4'b0010;
    for (int c = 0; c < 7; c++) add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    // Pointer persistence: search starts at 3
    for (int c = 0; c < 3; c++) add(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1);
    // Early release: owner 0 drops after 2 cycles, requester 1 gets a full tenure
    add(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1);
    for (int c = 0; c < 3; c++) add(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1);
    add(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);

    foreach (vecs[k]) step(vecs[k]);

    // O tracks data combinationally during a grant
    d0 = 4'b0000;
    add(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1);
    hv = vecs[vecs.size() - 1];
    step(hv);
    i0 = 4'b1010; #1;
    chk("o_track_a", {28'd0, o}, 32'h0000000a);
    i0 = 4'b0110; #1;
    chk("o_track_b", {28'd0, o}, 32'h00000006);
    hv.i0 = 4'b0110; hv.req = 4'b0000; hv.gnt = 4'b0000; hv.valid = 1'b0; hv.o = 4'b0000;
    step(hv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
